instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter ADDR_W, default 13: width of address immediate, base_address and mem_addr.
REQ-002 Parameter ARRAY_N, default 2: systolic array dimension; number of beats per LOAD_WEIGHT / LOAD_INPUT.
REQ-003 Parameter COMPUTE_LEN, default 3*ARRAY_N-1: number of cycles `valid` is held per COMPUTE.
REQ-004 Instruction width SHALL be ADDR_W+3: opcode in [ADDR_W+2:ADDR_W], immediate in [ADDR_W-1:0].
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous reset, active-low.
REQ-008 instr_valid  input  1  instruction present.
REQ-009 instruction  input  ADDR_W+3  opcode plus immediate.
REQ-010 instr_ready  output  1  sequencer can accept an instruction this cycle.
REQ-011 base_address  output  ADDR_W  registered base address.
REQ-012 mem_addr  output  ADDR_W  per-beat memory address.
REQ-013 load_weight  output  1  weight-load beat strobe.
REQ-014 load_input  output  1  input-load beat strobe.
REQ-015 valid  output  1  compute-enable to the array.
REQ-016 busy  output  1  multi-cycle operation in progress.
REQ-017 done  output  1  one-cycle pulse on completion of a multi-cycle operation.
REQ-018 err_opcode  output  1  one-cycle pulse on an illegal opcode.
REQ-019 halted  output  1  sequencer is in HALT.

Function
REQ-020 Opcodes SHALL be: 000 NOP, 001 LOAD_ADDR, 010 LOAD_WEIGHT, 011 LOAD_INPUT, 100 COMPUTE, 101 HALT; 110/111 are illegal.
REQ-021 States SHALL be IDLE, LOAD_W, LOAD_I, COMPUTE, HALT; all outputs SHALL be registered.
REQ-022 instr_ready SHALL be 1 only in IDLE; an instruction is accepted on a rising edge with instr_valid && instr_ready.
REQ-023 NOP accepted: no output change; remain in IDLE.
REQ-024 LOAD_ADDR accepted at edge t: base_address = immediate from cycle t+1; remain in IDLE; back-to-back LOAD_ADDRs each take effect.
REQ-025 LOAD_WEIGHT accepted at edge t: state LOAD_W and load_weight=1 for cycles t+1..t+ARRAY_N, with mem_addr = base_address + k on beat k (k=0..ARRAY_N-1), modulo 2^ADDR_W.
REQ-026 LOAD_INPUT: identical to REQ-025, using load_input and LOAD_I.
REQ-027 COMPUTE accepted at edge t: state COMPUTE and valid=1 for cycles t+1..t+COMPUTE_LEN; mem_addr held.
REQ-028 busy SHALL be 1 exactly while in LOAD_W, LOAD_I or COMPUTE.
REQ-029 On the cycle after the final beat: state IDLE, strobe low, done=1 for one cycle, instr_ready=1; a new instruction may be accepted on that edge.
REQ-030 At most one of load_weight, load_input, valid SHALL be 1 in any cycle.
REQ-031 Illegal opcode accepted: err_opcode=1 for the next cycle only; remain in IDLE; no other output changes.
REQ-032 HALT accepted: state HALT and halted=1 from next cycle; instr_ready=0 and all strobes 0 until reset.
REQ-033 instruction is ignored whenever instr_ready=0.
REQ-034 mem_addr wrap: base 2^ADDR_W-1 yields beat addresses 2^ADDR_W-1, 0, 1, ...

Reset
REQ-035 reset=0 at a rising edge: state IDLE; base_address, mem_addr = 0; load_weight, load_input, valid, busy, done, err_opcode, halted = 0; instr_ready=1 from the following cycle.
REQ-036 Reset SHALL take priority over any operation in progress, including mid-burst and in HALT; the aborted operation produces no done pulse.

Verification
REQ-037 LOAD_ADDR imm=0x0040, then LOAD_WEIGHT (ARRAY_N=2) -> load_weight high 2 cycles, mem_addr 0x0040, 0x0041; done pulse next cycle.
REQ-038 LOAD_ADDR imm=0x1FFF, then LOAD_INPUT -> mem_addr 0x1FFF, 0x0000; load_input 2 cycles.
REQ-039 COMPUTE, with instr_valid held high carrying LOAD_WEIGHT -> valid high 5 cycles, instr_ready 0 throughout; LOAD_WEIGHT accepted on the done cycle.
REQ-040 Opcode 111 -> err_opcode pulses 1 cycle; base_address unchanged; next NOP accepted.
REQ-041 HALT then LOAD_WEIGHT -> halted=1, instr_ready=0, no load_weight; reset=0 -> all outputs 0, instr_ready=1.
REQ-042 reset=0 on beat 2 of COMPUTE -> valid=0 next cycle, no done, base_address=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: single-issue instruction sequencer for a systolic array.
// Decodes a small opcode set and turns each accepted instruction into
// address-register updates, fixed-length load bursts or a compute window.
// Every output is driven from a register; the current FSM state is also
// exposed on state_dbg so checkers can bind to it directly.
//
// Handshake: an instruction transfers on a rising edge where
// instr_valid && instr_ready. instr_ready is high only while idle, and
// instruction is ignored in every cycle where instr_ready is low.
module instr_sequencer #(
    parameter int ADDR_W      = 13,
    parameter int ARRAY_N     = 2,
    parameter int COMPUTE_LEN = 3*ARRAY_N-1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [ADDR_W+2:0] instruction,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] base_address,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              load_weight,
    output logic              load_input,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic              err_opcode,
    output logic              halted,
    output logic [2:0]        state_dbg
);

    // Opcode map; 110 and 111 are reserved and flagged as illegal.
    localparam logic [2:0] OP_NOP         = 3'b000;
    localparam logic [2:0] OP_LOAD_ADDR   = 3'b001;
    localparam logic [2:0] OP_LOAD_WEIGHT = 3'b010;
    localparam logic [2:0] OP_LOAD_INPUT  = 3'b011;
    localparam logic [2:0] OP_COMPUTE     = 3'b100;
    localparam logic [2:0] OP_HALT        = 3'b101;

    // One counter serves both the load bursts and the compute window,
    // so it is sized for the longer of the two.
    localparam int CNT_MAX = (COMPUTE_LEN > ARRAY_N) ? COMPUTE_LEN : ARRAY_N;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT    = CNT_W'(ARRAY_N - 1);
    localparam logic [CNT_W-1:0] LAST_COMPUTE = CNT_W'(COMPUTE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_LOAD_I  = 3'd2,
        S_COMPUTE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   beat_cnt;
    logic [2:0]         opcode;
    logic [ADDR_W-1:0]  imm;
    logic               accept;

    assign state_dbg = state;

    // Split the instruction word and form the transfer condition.
    always_comb begin
        opcode = instruction[ADDR_W+2:ADDR_W];
        imm    = instruction[ADDR_W-1:0];
        accept = instr_valid && instr_ready;
    end

    // Sequencer FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            beat_cnt     <= '0;
            instr_ready  <= 1'b1;
            base_address <= '0;
            mem_addr     <= '0;
            load_weight  <= 1'b0;
            load_input   <= 1'b0;
            valid        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_opcode   <= 1'b0;
            halted       <= 1'b0;
        end else begin
            // done and err_opcode are single-cycle pulses.
            done       <= 1'b0;
            err_opcode <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (opcode)
                            OP_NOP: begin
                            end
                            OP_LOAD_ADDR: begin
                                base_address <= imm;
                            end
                            OP_LOAD_WEIGHT: begin
                                state       <= S_LOAD_W;
                                load_weight <= 1'b1;
                                busy        <= 1'b1;
                                instr_ready <= 1'b0;
                                mem_addr    <= base_address;
                                beat_cnt    <= '0;
                            end
                            OP_LOAD_INPUT: begin
                                state       <= S_LOAD_I;
                                load_input  <= 1'b1;
                                busy        <= 1'b1;
                                instr_ready <= 1'b0;
                                mem_addr    <= base_address;
                                beat_cnt    <= '0;
                            end
                            OP_COMPUTE: begin
                                // mem_addr keeps its last value during compute.
                                state       <= S_COMPUTE;
                                valid       <= 1'b1;
                                busy        <= 1'b1;
                                instr_ready <= 1'b0;
                                beat_cnt    <= '0;
                            end
                            OP_HALT: begin
                                state       <= S_HALT;
                                halted      <= 1'b1;
                                instr_ready <= 1'b0;
                            end
                            default: begin
                                err_opcode <= 1'b1;
                            end
                        endcase
                    end
                end
                S_LOAD_W, S_LOAD_I: begin
                    if (beat_cnt == LAST_BEAT) begin
                        state       <= S_IDLE;
                        load_weight <= 1'b0;
                        load_input  <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        instr_ready <= 1'b1;
                    end else begin
                        // Address wraps naturally at 2^ADDR_W.
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                S_COMPUTE: begin
                    if (beat_cnt == LAST_COMPUTE) begin
                        state       <= S_IDLE;
                        valid       <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        instr_ready <= 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                S_HALT: begin
                    // Only reset leaves HALT.
                end
                default: begin
                    state       <= S_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    load_weight <= 1'b0;
                    load_input  <= 1'b0;
                    valid       <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed steps for the documented scenarios,
// then randomized traffic, all checked cycle by cycle against a schedule
// model that expands each accepted instruction into its future output cycles.
module tb_instr_sequencer;

    localparam int ADDR_W      = 13;
    localparam int ARRAY_N     = 2;
    localparam int COMPUTE_LEN = 3*ARRAY_N-1;
    localparam int INSTR_W     = ADDR_W + 3;

    // clock / reset / DUT signals
    logic               clk;
    logic               reset;
    logic               instr_valid;
    logic [INSTR_W-1:0] instruction;
    logic               instr_ready;
    logic [ADDR_W-1:0]  base_address;
    logic [ADDR_W-1:0]  mem_addr;
    logic               load_weight;
    logic               load_input;
    logic               valid;
    logic               busy;
    logic               done;
    logic               err_opcode;
    logic               halted;
    logic [2:0]         state_dbg;

    instr_sequencer #(
        .ADDR_W(ADDR_W),
        .ARRAY_N(ARRAY_N),
        .COMPUTE_LEN(COMPUTE_LEN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .instr_valid(instr_valid),
        .instruction(instruction),
        .instr_ready(instr_ready),
        .base_address(base_address),
        .mem_addr(mem_addr),
        .load_weight(load_weight),
        .load_input(load_input),
        .valid(valid),
        .busy(busy),
        .done(done),
        .err_opcode(err_opcode),
        .halted(halted),
        .state_dbg(state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // expected output snapshot for one cycle
    typedef struct packed {
        logic              rdy;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] mem;
        logic              lw;
        logic              li;
        logic              vl;
        logic              bsy;
        logic              dn;
        logic              err;
        logic              hlt;
    } outs_t;

    // scoreboard: queued future cycles, plus architectural model state
    outs_t             exp_q[$];
    outs_t             m_cur;
    logic [ADDR_W-1:0] m_base;
    logic [ADDR_W-1:0] m_mem;
    logic              m_halted;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    function automatic outs_t idle_out();
        outs_t o;
        o      = '0;
        o.rdy  = !m_halted;
        o.base = m_base;
        o.mem  = m_mem;
        o.hlt  = m_halted;
        return o;
    endfunction

    function automatic outs_t beat_out(input logic lw, input logic li, input logic vl,
                                       input logic [ADDR_W-1:0] addr);
        outs_t o;
        o      = '0;
        o.base = m_base;
        o.mem  = addr;
        o.lw   = lw;
        o.li   = li;
        o.vl   = vl;
        o.bsy  = 1'b1;
        return o;
    endfunction

    function automatic outs_t done_out(input logic [ADDR_W-1:0] addr);
        outs_t o;
        o      = '0;
        o.rdy  = 1'b1;
        o.base = m_base;
        o.mem  = addr;
        o.dn   = 1'b1;
        return o;
    endfunction

    // Advance the model by one rising edge with the given inputs.
    task automatic model_step(input logic rst_n, input logic v, input logic [INSTR_W-1:0] ins);
        logic [2:0]        op;
        logic [ADDR_W-1:0] imm;
        logic [ADDR_W-1:0] a;
        logic              err;
        op  = ins[INSTR_W-1:ADDR_W];
        imm = ins[ADDR_W-1:0];
        err = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            m_base   = '0;
            m_mem    = '0;
            m_halted = 1'b0;
            m_cur    = idle_out();
            return;
        end
        if (v && m_cur.rdy) begin
            case (op)
                3'd1: m_base = imm;
                3'd2, 3'd3: begin
                    for (int k = 0; k < ARRAY_N; k++) begin
                        a = m_base + ADDR_W'(k);
                        exp_q.push_back(beat_out(op == 3'd2, op == 3'd3, 1'b0, a));
                    end
                    a = m_base + ADDR_W'(ARRAY_N - 1);
                    exp_q.push_back(done_out(a));
                end
                3'd4: begin
                    for (int k = 0; k < COMPUTE_LEN; k++)
                        exp_q.push_back(beat_out(1'b0, 1'b0, 1'b1, m_mem));
                    exp_q.push_back(done_out(m_mem));
                end
                3'd5: m_halted = 1'b1;
                3'd6, 3'd7: err = 1'b1;
                default: begin
                end
            endcase
        end
        if (exp_q.size() > 0) begin
            m_cur = exp_q.pop_front();
        end else begin
            m_cur     = idle_out();
            m_cur.err = err;
        end
        m_mem = m_cur.mem;
    endtask

    task automatic compare_all();
        outs_t obs;
        obs = {instr_ready, base_address, mem_addr, load_weight, load_input,
               valid, busy, done, err_opcode, halted};
        checks++;
        assert (obs === m_cur) passed++;
        else $error("FAIL outputs cyc=%0d got=%h exp=%h", cyc, obs, m_cur);
        checks++;
        assert ($countones({load_weight, load_input, valid}) <= 1) passed++;
        else $error("FAIL strobe_onehot cyc=%0d got=%b exp=at most one set", cyc,
                    {load_weight, load_input, valid});
    endtask

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    endtask

    // driver: apply inputs, take one edge, update model, sample #1 later
    task automatic step(input logic rst_n, input logic v, input logic [INSTR_W-1:0] ins);
        reset       = rst_n;
        instr_valid = v;
        instruction = ins;
        @(posedge clk);
        model_step(rst_n, v, ins);
        #1;
        cyc++;
        compare_all();
    endtask

    function automatic logic [INSTR_W-1:0] mk(input logic [2:0] op, input logic [ADDR_W-1:0] imm);
        return {op, imm};
    endfunction

    int valid_cnt;
    int ready_seen;

    initial begin
        logic [INSTR_W-1:0] nop;
        nop = mk(3'd0, '0);
        reset = 1'b0; instr_valid = 1'b0; instruction = '0;

        // reset state
        step(1'b0, 1'b0, nop);
        step(1'b0, 1'b0, nop);
        check1("rst_ready", 32'(instr_ready), 32'd1);
        check1("rst_base", 32'(base_address), 32'd0);
        check1("rst_busy", 32'(busy), 32'd0);

        // LOAD_ADDR 0x40 then LOAD_WEIGHT
        step(1'b1, 1'b1, mk(3'd1, 13'h0040));
        check1("ldaddr_base", 32'(base_address), 32'h40);
        step(1'b1, 1'b1, mk(3'd2, 13'h0123));
        check1("lw_beat0_addr", 32'(mem_addr), 32'h40);
        check1("lw_beat0_strobe", 32'(load_weight), 32'd1);
        step(1'b1, 1'b0, nop);
        check1("lw_beat1_addr", 32'(mem_addr), 32'h41);
        check1("lw_beat1_strobe", 32'(load_weight), 32'd1);
        step(1'b1, 1'b0, nop);
        check1("lw_done", 32'(done), 32'd1);
        check1("lw_end_strobe", 32'(load_weight), 32'd0);
        step(1'b1, 1'b0, nop);
        check1("lw_done_pulse", 32'(done), 32'd0);

        // wrap: LOAD_ADDR 0x1FFF then LOAD_INPUT
        step(1'b1, 1'b1, mk(3'd1, 13'h1FFF));
        step(1'b1, 1'b1, mk(3'd3, 13'h0000));
        check1("li_wrap_beat0", 32'(mem_addr), 32'h1FFF);
        check1("li_beat0_strobe", 32'(load_input), 32'd1);
        step(1'b1, 1'b0, nop);
        check1("li_wrap_beat1", 32'(mem_addr), 32'h0000);
        check1("li_beat1_strobe", 32'(load_input), 32'd1);
        step(1'b1, 1'b0, nop);
        check1("li_done", 32'(done), 32'd1);

        // COMPUTE with LOAD_WEIGHT held on the bus
        valid_cnt = 0; ready_seen = 0;
        step(1'b1, 1'b1, mk(3'd4, 13'h0000));
        valid_cnt += int'(valid); ready_seen += int'(instr_ready);
        for (int i = 0; i < COMPUTE_LEN - 1; i++) begin
            step(1'b1, 1'b1, mk(3'd2, 13'h0000));
            valid_cnt += int'(valid); ready_seen += int'(instr_ready);
        end
        check1("compute_valid_cycles", 32'(valid_cnt), 32'(COMPUTE_LEN));
        check1("compute_ready_low", 32'(ready_seen), 32'd0);
        step(1'b1, 1'b1, mk(3'd2, 13'h0000));
        check1("compute_done", 32'(done), 32'd1);
        check1("compute_done_ready", 32'(instr_ready), 32'd1);
        step(1'b1, 1'b1, mk(3'd2, 13'h0000));
        check1("lw_after_done", 32'(load_weight), 32'd1);
        step(1'b1, 1'b0, nop);
        step(1'b1, 1'b0, nop);

        // illegal opcode
        step(1'b1, 1'b1, mk(3'd7, 13'h0ABC));
        check1("err_pulse", 32'(err_opcode), 32'd1);
        check1("err_base_kept", 32'(base_address), 32'h1FFF);
        step(1'b1, 1'b1, nop);
        check1("err_cleared", 32'(err_opcode), 32'd0);
        check1("nop_ready", 32'(instr_ready), 32'd1);

        // HALT then LOAD_WEIGHT, then reset out of HALT
        step(1'b1, 1'b1, mk(3'd5, 13'h0000));
        check1("halt_flag", 32'(halted), 32'd1);
        check1("halt_ready", 32'(instr_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, mk(3'd2, 13'h0000));
            check1("halt_no_lw", 32'(load_weight), 32'd0);
        end
        step(1'b0, 1'b0, nop);
        check1("halt_reset_flag", 32'(halted), 32'd0);
        check1("halt_reset_ready", 32'(instr_ready), 32'd1);

        // reset during COMPUTE beat 2
        step(1'b1, 1'b1, mk(3'd1, 13'h0155));
        step(1'b1, 1'b1, mk(3'd4, 13'h0000));
        step(1'b1, 1'b0, nop);
        step(1'b0, 1'b0, nop);
        check1("abort_valid", 32'(valid), 32'd0);
        check1("abort_base", 32'(base_address), 32'd0);
        step(1'b1, 1'b0, nop);
        check1("abort_no_done", 32'(done), 32'd0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            int r;
            logic [2:0] op;
            logic [ADDR_W-1:0] imm;
            r = int'($urandom_range(0, 99));
            if (r < 10)      op = 3'd0;
            else if (r < 30) op = 3'd1;
            else if (r < 50) op = 3'd2;
            else if (r < 65) op = 3'd3;
            else if (r < 82) op = 3'd4;
            else if (r < 85) op = 3'd5;
            else             op = 3'($urandom_range(6, 7));
            if ($urandom_range(0, 3) == 0) imm = 13'h1FFF - ADDR_W'($urandom_range(0, 2));
            else                           imm = ADDR_W'($urandom);
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), mk(op, imm));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
